// File: rtl/game_ctrl.sv
// Match controller: scores ball exits and sequences serve/play/game-over, driving the ball stage reset and entropy.
// Optional build macro SERVE_TO_LOSER_EN biases the serve direction toward the player who lost the last point.
module game_ctrl #(
  parameter int unsigned WIN_SCORE   = 9,
  parameter int unsigned SCORE_WIDTH = 4,
  parameter int unsigned SERVE_DELAY = 2000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   out_left,
  input  logic                   out_right,
  output logic                   ball_reset,
  output logic [4:0]             entropy,
  output logic [SCORE_WIDTH-1:0] lscore,
  output logic [SCORE_WIDTH-1:0] rscore,
  output logic                   serving,
  output logic                   game_over,
  output logic                   winner
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SERVE = 2'd1;
  localparam logic [1:0] PLAY  = 2'd2;
  localparam logic [1:0] OVER  = 2'd3;

  localparam int unsigned CW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CW-1:0]          CNT_LOAD = CW'(SERVE_DELAY - 1);
  localparam logic [SCORE_WIDTH-1:0] WIN      = SCORE_WIDTH'(WIN_SCORE);
  localparam logic [SCORE_WIDTH-1:0] ONE      = SCORE_WIDTH'(1);

  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SCORE_WIDTH-1:0] lscore_d, rscore_d;
  logic [SCORE_WIDTH-1:0] l_inc, r_inc;
  logic                   winner_d;
  logic                   sync1, sync2, sync3, start_pulse;
  logic [15:0]            lfsr;

`ifdef SERVE_TO_LOSER_EN
  logic loser_valid_q, loser_valid_d;
  logic loser_right_q, loser_right_d;
`endif

  assign l_inc = lscore + ONE;
  assign r_inc = rscore + ONE;

  // Registered edge detect so the pulse lands one cycle after the second sync flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      sync3       <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      sync1       <= start;
      sync2       <= sync1;
      sync3       <= sync2;
      start_pulse <= sync2 & ~sync3;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr <= 16'hACE1;
    else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lscore_d = lscore;
    rscore_d = rscore;
    winner_d = winner;
`ifdef SERVE_TO_LOSER_EN
    loser_valid_d = loser_valid_q;
    loser_right_d = loser_right_q;
`endif
    case (state_q)
      IDLE, OVER: begin
        if (start_pulse) begin
          state_d  = SERVE;
          cnt_d    = CNT_LOAD;
          lscore_d = '0;
          rscore_d = '0;
`ifdef SERVE_TO_LOSER_EN
          loser_valid_d = 1'b0;
`endif
        end
      end
      SERVE: begin
        if (cnt_q == '0) state_d = PLAY;
        else             cnt_d   = cnt_q - CW'(1);
      end
      PLAY: begin
        if (out_left || out_right) begin
          state_d = SERVE;
          cnt_d   = CNT_LOAD;
`ifdef SERVE_TO_LOSER_EN
          loser_valid_d = out_left ^ out_right;
          loser_right_d = out_right;
`endif
          if (out_left && !out_right && rscore < WIN) begin
            rscore_d = r_inc;
            if (r_inc == WIN) begin
              state_d  = OVER;
              winner_d = 1'b1;
            end
          end else if (out_right && !out_left && lscore < WIN) begin
            lscore_d = l_inc;
            if (l_inc == WIN) begin
              state_d  = OVER;
              winner_d = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next-state value so they align with state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lscore     <= '0;
      rscore     <= '0;
      winner     <= 1'b0;
      ball_reset <= 1'b1;
      serving    <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lscore     <= lscore_d;
      rscore     <= rscore_d;
      winner     <= winner_d;
      ball_reset <= (state_d != PLAY);
      serving    <= (state_d == SERVE);
      game_over  <= (state_d == OVER);
    end
  end

`ifdef SERVE_TO_LOSER_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loser_valid_q <= 1'b0;
      loser_right_q <= 1'b0;
    end else begin
      loser_valid_q <= loser_valid_d;
      loser_right_q <= loser_right_d;
    end
  end

  // Direction class lives in entropy[4:3]: equal bits serve left, differing bits serve right.
  always_comb begin
    entropy = lfsr[4:0];
    if (loser_valid_q)
      entropy[4:3] = loser_right_q ? {lfsr[4], ~lfsr[4]} : {lfsr[4], lfsr[4]};
  end
`else
  assign entropy = lfsr[4:0];
`endif

endmodule
